aes256_key_sched_ctrl: RTL and testbench
========================================

Name: aes256_key_sched_ctrl

Overview:
Sequencer for the AES-256 key-expansion datapath. It accepts one 256-bit cipher key over a valid/ready handshake. It then iterates a single instance of the combinational 8-word round-key generator (inputs: 256-bit previous block k[0:255] and round index r[0:4]; output: next 256-bit block) for r = 1..7, and stores the 15 resulting 128-bit round keys in an internal bank. Cipher round logic reads the bank through an indexed read port once keys_valid_o is high.

Parameters:
NR, 14, number of cipher rounds; round keys stored = NR+1; only 14 is supported.
RK_W, 128, round-key width in bits.

Ports:
clk_i  input  1  single clock; all state updates on rising edge.
reset_i  input  1  asynchronous, active-high reset.
key_v_i  input  1  cipher key valid.
key_i  input  [0:255]  cipher key; bit 0 is MSB of byte 0.
ready_o  output  1  controller can accept a key (high only in IDLE).
rk_addr_i  input  [3:0]  round-key index 0..14.
rk_o  output  [0:127]  combinational read of bank[rk_addr_i]; all zeros when rk_addr_i = 15.
keys_valid_o  output  1  bank holds a complete schedule for the last accepted key.
busy_o  output  1  expansion in progress.
done_o  output  1  one-cycle pulse when expansion completes.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, ready_o=1, busy_o=0, done_o=0, keys_valid_o=0.
  - r counter = 0, work register = 0, all 15 bank entries = 0.
- States: IDLE, EXPAND.
- Handshake: key accepted on a rising edge where key_v_i & ready_o. key_v_i is ignored when ready_o=0; there is no queuing.
- Edge of acceptance:
  - bank[0] <= key_i[0:127], bank[1] <= key_i[128:255].
  - work <= key_i, r <= 1.
  - keys_valid_o <= 0, state <= EXPAND.
- EXPAND, each cycle, with gen = generator(work, r):
  - bank[2r] <= gen[0:127].
  - bank[2r+1] <= gen[128:255] only if 2r+1 <= 14. For r=7, gen[128:255] is discarded.
  - work <= gen, r <= r+1.
  - When r=7: state <= IDLE, keys_valid_o <= 1, done_o <= 1 for exactly one cycle.
- Generator r input is driven from the r counter. It must never see r=0 while in EXPAND, because rc is derived from r-1.
- Latency: done_o and keys_valid_o assert 8 cycles after the acceptance edge (1 load cycle + 7 expand cycles). ready_o is low for 7 cycles. Back-to-back keys are accepted every 8 cycles.
- busy_o = (state == EXPAND). ready_o = (state == IDLE).
- rk_o is purely combinational from the bank; no read latency. During EXPAND, reads return partially updated or stale contents, and consumers must gate on keys_valid_o.
- A new key accepted while keys_valid_o=1 drops keys_valid_o on the acceptance edge. bank[0..1] are overwritten on that edge, the rest progressively.
- Reset mid-EXPAND aborts the expansion: bank cleared, no done_o pulse.
- key_i only needs to be stable on the acceptance edge; later changes are ignored.

Test Plan:
- Reset, then idle → ready_o=1, keys_valid_o=0, rk_o=0 for every address 0..15.
- Accept FIPS-197 C.3 key 000102…1f → ready_o low for exactly 7 cycles; done_o pulses once, 8 cycles after acceptance. Then:
  - rk0 = 000102030405060708090a0b0c0d0e0f
  - rk1 = 101112131415161718191a1b1c1d1e1f
  - rk2 = a573c29fa176c498a97fce93a572c09c
  - rk14 = 24fc79ccbf0979e9371ac23c6d68de36
- Hold key_v_i=1 with a different key throughout EXPAND → second key ignored until ready_o=1. It is then accepted, and keys_valid_o falls on that edge.
- Assert reset_i asynchronously (mid-cycle) at EXPAND r=4 → outputs reach reset values immediately; no done_o. A subsequent full expansion gives correct rk14.
- rk_addr_i=15 with keys_valid_o=1 → rk_o = 0.
- Two back-to-back keys (all-zero key, then all-ones key) → bank matches a reference model after each done_o.

Source files
------------

// File: rtl/aes256_key_sched_ctrl.sv
`timescale 1ns/1ps
// aes256_key_sched_ctrl
// Sequencer for the AES-256 key expansion. Accepts one 256-bit cipher key on a
// valid/ready handshake, then steps a single 8-word round-key generator through
// r = 1..7 and fills a 15-entry bank of 128-bit round keys.
//
// Ports:
//   clk_i         clock, rising-edge active
//   reset_i       asynchronous active-high reset
//   key_v_i       cipher key valid
//   key_i         cipher key, bit 0 = MSB of byte 0
//   ready_o       key can be accepted (IDLE)
//   rk_addr_i     round-key read index 0..14 (15 reads as zero)
//   rk_o          combinational read of the bank
//   keys_valid_o  bank holds a complete schedule for the last accepted key
//   busy_o        expansion in progress
//   done_o        one-cycle pulse when expansion completes
//
// State | meaning
// IDLE   | waiting for a key, ready_o high
// EXPAND | generator running, one 8-word block per cycle

module aes256_key_sched_ctrl #(
  parameter int NR   = 14,
  parameter int RK_W = 128
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            key_v_i,
  input  logic [0:255]    key_i,
  output logic            ready_o,
  input  logic [3:0]      rk_addr_i,
  output logic [0:RK_W-1] rk_o,
  output logic            keys_valid_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_round;
  logic [0:255]      r_work;
  logic [0:RK_W-1]   r_bank [0:NR];
  logic              r_done;
  logic              r_keys_valid;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [0:255]      w_gen;
  logic [3:0]        w_idx_lo;
  logic [3:0]        w_idx_hi;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, which maps 0 to 0) plus affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One generator step: previous 8 words -> next 8 words for round index r.
  // rc = 2^(r-1), so r must be 1..7 whenever the result is used.
  function automatic logic [0:255] key_gen(input logic [0:255] k, input logic [3:0] r);
    logic [31:0] p [8];
    logic [31:0] n [8];
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) p[i] = k[32*i +: 32];
    rc   = 8'h01 << (r - 4'd1);
    n[0] = p[0] ^ sub_word({p[7][23:0], p[7][31:24]}) ^ {rc, 24'h000000};
    n[1] = p[1] ^ n[0];
    n[2] = p[2] ^ n[1];
    n[3] = p[3] ^ n[2];
    n[4] = p[4] ^ sub_word(n[3]);
    n[5] = p[5] ^ n[4];
    n[6] = p[6] ^ n[5];
    n[7] = p[7] ^ n[6];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  assign w_gen    = key_gen(r_work, r_round);
  assign w_idx_lo = {r_round[2:0], 1'b0};
  assign w_idx_hi = {r_round[2:0], 1'b1};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_v_i) begin
          w_load      = 1'b1;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_step = 1'b1;
        if (r_round == 4'd7) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_work       <= '0;
      r_round      <= '0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) r_bank[i] <= '0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_bank[0]    <= key_i[0:127];
        r_bank[1]    <= key_i[128:255];
        r_work       <= key_i;
        r_round      <= 4'd1;
        r_keys_valid <= 1'b0;
      end else if (w_step) begin
        r_bank[w_idx_lo] <= w_gen[0:127];
        // the upper half of the r=7 block would be entry 15, which does not exist
        if (!w_last) r_bank[w_idx_hi] <= w_gen[128:255];
        r_work  <= w_gen;
        r_round <= r_round + 4'd1;
        if (w_last) r_keys_valid <= 1'b1;
      end
    end
  end

  assign rk_o         = (rk_addr_i == 4'd15) ? '0 : r_bank[rk_addr_i];
  assign ready_o      = (r_state == IDLE);
  assign busy_o       = (r_state == EXPAND);
  assign done_o       = r_done;
  assign keys_valid_o = r_keys_valid;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
`timescale 1ns/1ps
// Directed bench for aes256_key_sched_ctrl. Known-answer round keys for the
// 000102..1f key, plus an independent FIPS-style expansion model for other keys.

module tb_aes256_key_sched_ctrl;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          key_v_i;
  logic [0:255]  key_i;
  logic          ready_o;
  logic [3:0]    rk_addr_i;
  logic [0:127]  rk_o;
  logic          keys_valid_o;
  logic          busy_o;
  logic          done_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [15];

  localparam logic [255:0] KF = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K3 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7bf1c3a5d0a4b7e3c9;

  aes256_key_sched_ctrl dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .key_v_i      (key_v_i),
    .key_i        (key_i),
    .ready_o      (ready_o),
    .rk_addr_i    (rk_addr_i),
    .rk_o         (rk_o),
    .keys_valid_o (keys_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box by exhaustive inverse search and bitwise affine transform
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] tb_sub(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = tb_sub({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = tb_mul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = tb_sub(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // called at a falling edge; steps of 0.1 ns stay well inside the low phase
  task automatic check_bank(input string tag);
    for (int a = 0; a < 15; a++) begin
      rk_addr_i = a[3:0];
      #0.1;
      check($sformatf("%s rk%0d", tag, a), rk_o, exp_rk[a]);
    end
    rk_addr_i = 4'd15;
    #0.1;
    check({tag, " rk15"}, rk_o, 128'h0);
  endtask

  // key ka accepted from IDLE; kb held valid throughout and taken once ready returns
  task automatic run_pair(input logic [255:0] ka, input logic [255:0] kb, input string tag);
    int c;
    key_v_i = 1'b1;
    key_i   = ka;
    @(negedge clk_i);
    check({tag, " kv drop A"}, keys_valid_o, 1'b0);
    check({tag, " ready low A"}, ready_o, 1'b0);
    key_i = kb;
    c = 1;
    while (!ready_o && c < 20) begin @(negedge clk_i); c++; end
    check({tag, " ready return A"}, c, 8);
    check({tag, " done A"}, done_o, 1'b1);
    check({tag, " kv A"}, keys_valid_o, 1'b1);
    model(ka);
    check_bank({tag, " A"});
    @(negedge clk_i);
    check({tag, " B accepted"}, ready_o, 1'b0);
    check({tag, " kv drop B"}, keys_valid_o, 1'b0);
    key_v_i = 1'b0;
    key_i   = '0;
    c = 1;
    while (!done_o && c < 20) begin @(negedge clk_i); c++; end
    check({tag, " done B"}, c, 8);
    model(kb);
    check_bank({tag, " B"});
    @(negedge clk_i);
  endtask

  initial begin
    int low_cnt;
    int done_cnt;
    int done_at;
    int c;
    reset_i   = 1'b1;
    key_v_i   = 1'b0;
    key_i     = '0;
    rk_addr_i = 4'd0;
    build_sbox();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    check("reset ready", ready_o, 1'b1);
    check("reset busy", busy_o, 1'b0);
    check("reset done", done_o, 1'b0);
    check("reset kv", keys_valid_o, 1'b0);
    for (int a = 0; a < 16; a++) begin
      rk_addr_i = a[3:0];
      #0.1;
      check($sformatf("reset rk%0d", a), rk_o, 128'h0);
    end

    // known-answer key, latency and pulse width
    key_v_i = 1'b1;
    key_i   = KF;
    @(negedge clk_i);
    key_v_i = 1'b0;
    key_i   = {8{32'hdeadbeef}};
    check("kat busy", busy_o, 1'b1);
    low_cnt  = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int cy = 1; cy <= 12; cy++) begin
      if (!ready_o) low_cnt++;
      if (done_o) begin done_cnt++; done_at = cy; end
      @(negedge clk_i);
    end
    check("kat ready low cycles", low_cnt, 7);
    check("kat done count", done_cnt, 1);
    check("kat done cycle", done_at, 8);
    check("kat kv", keys_valid_o, 1'b1);
    check("kat busy idle", busy_o, 1'b0);
    rk_addr_i = 4'd0;  #0.1; check("kat rk0", rk_o, 128'h000102030405060708090a0b0c0d0e0f);
    rk_addr_i = 4'd1;  #0.1; check("kat rk1", rk_o, 128'h101112131415161718191a1b1c1d1e1f);
    rk_addr_i = 4'd2;  #0.1; check("kat rk2", rk_o, 128'ha573c29fa176c498a97fce93a572c09c);
    rk_addr_i = 4'd14; #0.1; check("kat rk14", rk_o, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rk_addr_i = 4'd15; #0.1; check("kat rk15", rk_o, 128'h0);
    model(KF);
    check_bank("kat model");

    // key held valid during EXPAND is ignored until ready returns
    run_pair(K2, K3, "hold");

    // asynchronous reset while r = 4
    key_v_i = 1'b1;
    key_i   = KF;
    @(negedge clk_i);
    key_v_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("abort ready", ready_o, 1'b1);
    check("abort busy", busy_o, 1'b0);
    check("abort kv", keys_valid_o, 1'b0);
    check("abort done", done_o, 1'b0);
    rk_addr_i = 4'd0; #0.1; check("abort rk0", rk_o, 128'h0);
    rk_addr_i = 4'd5; #0.1; check("abort rk5", rk_o, 128'h0);
    @(negedge clk_i);
    reset_i  = 1'b0;
    done_cnt = 0;
    for (int cy = 0; cy < 10; cy++) begin
      if (done_o) done_cnt++;
      @(negedge clk_i);
    end
    check("abort no done", done_cnt, 0);
    key_v_i = 1'b1;
    key_i   = KF;
    @(negedge clk_i);
    key_v_i = 1'b0;
    c = 1;
    while (!done_o && c < 20) begin @(negedge clk_i); c++; end
    check("rerun done", c, 8);
    rk_addr_i = 4'd14; #0.1; check("rerun rk14", rk_o, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rk_addr_i = 4'd15; #0.1; check("rerun rk15", rk_o, 128'h0);
    @(negedge clk_i);

    // back-to-back all-zero then all-ones
    run_pair({256{1'b0}}, {256{1'b1}}, "b2b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
